muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Owns the HI/LO multiply/divide resource of the core and sequences its multi-cycle operations.
- Accepts one operation at a time from the execute stage.
- Drives the busy flag that the hazard/stall logic uses to hold any mult/div/mfhi/mflo/mthi/mtlo/mul behind it.
- Exposes HI/LO to the execute stage for mfhi/mflo, and the low word for the three-operand mul.

Parameters:
- MUL_LATENCY, 3: cycles busy for mult/multu/mul; legal range 1..8.
- DIV_CYCLES, 32: iteration cycles for div/divu; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered this cycle.
- op  in  3  opcode: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mul; 0 reserved (ignored).
- src_a  in  32  rs operand (dividend / multiplicand / mthi-mtlo data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception flush; blocks acceptance this cycle.
- abort  in  1  kills the in-flight operation.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.
- mul_done  out  1  one-cycle pulse when mul_result is valid.
- mul_result  out  32  low 32 bits of the signed product for op 7.

Behaviour:
- Reset (asynchronous, resetn low): state IDLE, busy=0, hi=0, lo=0, mul_done=0, mul_result=0, counters 0. Any in-flight operation is discarded.
- Accept condition: op_valid && !flush && state==IDLE. Otherwise op_valid is ignored. op_valid while busy is a protocol violation; it has no effect.
- States: IDLE, MUL, DIV_RUN, DIV_FIX. busy = (state != IDLE), registered.
- mthi/mtlo:
  - Accepted in IDLE only; hi (or lo) takes src_a at the accepting edge.
  - busy never rises; the new value is visible on the next cycle.
- mult/multu/mul:
  - At the accepting edge: latch operands, state=MUL, cnt=MUL_LATENCY-1.
  - In MUL: if cnt==0, complete at this edge and return to IDLE; else decrement cnt.
  - busy is high for exactly MUL_LATENCY cycles.
  - mult/multu: {hi,lo} takes the 64-bit signed/unsigned product at completion.
  - mul: HI/LO unchanged; mul_result takes the product low word and mul_done pulses for the first cycle after completion.
- div/divu:
  - At the accepting edge: latch operand magnitudes (signed ops) or raw values (divu), record the quotient and remainder signs, state=DIV_RUN, cnt=DIV_CYCLES-1.
  - DIV_RUN: one restoring-division quotient bit per cycle, MSB first. When cnt==0, go to DIV_FIX.
  - DIV_FIX: one cycle; apply the sign correction (quotient sign = sign a XOR sign b; remainder sign = sign a), write lo=quotient and hi=remainder, return to IDLE.
  - busy is high for DIV_CYCLES+1 = 33 cycles.
- Divide by zero: full 33-cycle sequence, HI/LO unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (32-bit wrap).
- abort:
  - In any non-IDLE state, returns to IDLE at the next edge with no HI/LO or mul_result write and no mul_done.
  - abort at the completing edge wins: no write.
  - abort in IDLE has no effect. abort and op_valid in the same IDLE cycle: op is accepted (abort applies only to an in-flight op).
- flush has no effect on an in-flight operation; it only gates acceptance.
- Back-to-back operations: a new op may be accepted in the first IDLE cycle after completion. Its operands read HI/LO-independent sources, so there is no forwarding.
- hi/lo are pure registers; mfhi/mflo reads are combinational from these outputs, and the stall logic guarantees busy=0 before such reads.

Test Plan:
1. Reset mid-divide: assert resetn=0 in DIV_RUN cycle 10 -> busy=0 and hi=lo=0 immediately; after release, mthi 0x1234 -> hi=0x00001234 next cycle, busy never 1.
2. mult a=0xFFFFFFFE (-2), b=3, MUL_LATENCY=3 -> busy high exactly 3 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. div a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 -> lo=14, hi=2.
4. div by zero with hi=0xAAAA, lo=0x5555 preloaded -> 33 busy cycles, hi/lo unchanged. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
5. mul 6 x 7 -> mul_done single pulse with mul_result=42; hi/lo unchanged. op_valid with flush=1 -> no acceptance, busy stays 0.
6. Start div, assert abort on cycle 33 (the completing DIV_FIX edge) -> no write, busy drops next cycle. Repeat with abort in MUL cycle 1 -> no write. op_valid mult during busy -> ignored; hi/lo reflect only the original op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO multiply/divide sequencer with busy flag
//
// Owns HI/LO and sequences multi-cycle mult/multu/mul and div/divu,
// plus single-cycle mthi/mtlo writes.
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   op_valid, op         operation offer; op 1 mult, 2 multu, 3 div, 4 divu,
//                        5 mthi, 6 mtlo, 7 mul, 0 ignored
//   src_a, src_b         rs / rt operands
//   flush                blocks acceptance this cycle
//   abort                kills the in-flight operation
//   busy                 operation in flight (registered)
//   hi, lo               HI/LO registers
//   mul_done, mul_result one-cycle pulse with product low word for mul

module muldiv_sequencer #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        abort,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_done,
  output logic [31:0] mul_result
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MUL   = 3'd7;

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV_RUN,
    S_DIV_FIX
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  // a_q: multiplicand, or dividend magnitude that shifts into the quotient
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        mul_done_q, mul_done_d;
  logic [31:0] mul_result_q, mul_result_d;

  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_s, prod_u;
  logic [32:0] shifted, diff;
  logic        sub_ok;

  assign accept = op_valid && !flush && (state_q == S_IDLE);

  // Magnitudes only for signed divide; divu keeps raw operands.
  assign a_neg = (op == OP_DIV) && src_a[31];
  assign b_neg = (op == OP_DIV) && src_b[31];
  assign a_mag = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag = b_neg ? (~src_b + 32'd1) : src_b;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, a_q[31]};
  assign diff    = shifted - {1'b0, b_q};
  assign sub_ok  = !diff[32];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    dz_d         = dz_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_done_d   = 1'b0;
    mul_result_d = mul_result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU, OP_MUL: begin
              op_d    = op;
              a_d     = src_a;
              b_d     = src_b;
              cnt_d   = MUL_CNT_INIT;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a_mag;
              b_d     = b_mag;
              rem_d   = 32'd0;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
              dz_d    = (src_b == 32'd0);
              cnt_d   = DIV_CNT_INIT;
              state_d = S_DIV_RUN;
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == 6'd0) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MUL: begin
              mul_result_d = prod_s[31:0];
              mul_done_d   = 1'b1;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      S_DIV_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          rem_d = sub_ok ? diff[31:0] : shifted[31:0];
          a_d   = {a_q[30:0], sub_ok};
          if (cnt_q == 6'd0) begin
            state_d = S_DIV_FIX;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_DIV_FIX: begin
        state_d = S_IDLE;
        // Divide by zero still runs the full sequence but leaves HI/LO alone.
        if (!abort && !dz_q) begin
          lo_d = q_neg_q ? (~a_q + 32'd1) : a_q;
          hi_d = r_neg_q ? (~rem_q + 32'd1) : rem_q;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      cnt_q        <= 6'd0;
      op_q         <= 3'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 32'd0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      dz_q         <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_done_q   <= 1'b0;
      mul_result_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      dz_q         <= dz_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_done_q   <= mul_done_d;
      mul_result_q <= mul_result_d;
    end
  end

  assign busy       = busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_done   = mul_done_q;
  assign mul_result = mul_result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer

module tb_muldiv_sequencer;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        abort;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_done;
  logic [31:0] mul_result;

  int vectors = 0;
  int errors  = 0;

  muldiv_sequencer #(
    .MUL_LATENCY(3),
    .DIV_CYCLES (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .abort     (abort),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .mul_done  (mul_done),
    .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: offers the op for one edge, then counts busy
  // cycles and returns at the first negedge with busy low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int bc);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int bc;
    resetn = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = 0; src_b = 0;
    flush = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    vectors++; if (mul_done !== 1'b0 || mul_result !== 32'd0) begin errors++; $display("FAIL reset_mul got %b/%h want 0/0", mul_done, mul_result); end
    resetn = 1'b1;
    @(negedge clk);
    // Reset mid-divide, in DIV_RUN cycle 10.
    run_op(3'd5, 32'h0000_BEEF, 32'd0, bc);
    op_valid = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    repeat (9) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy got %0b want 1", busy); end
    #2 resetn = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midreset_async got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op(3'd5, 32'h0000_1234, 32'd0, bc);
    vectors++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi got %h want 00001234", hi); end
    vectors++; if (bc !== 0) begin errors++; $display("FAIL mthi_busy got %0d cycles want 0", bc); end
  endtask

  task automatic test_mult;
    int bc;
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc);
    vectors++; if (bc !== 3) begin errors++; $display("FAIL mult_busy got %0d want 3", bc); end
    vectors++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_hilo got %h_%h want ffffffff_fffffffa", hi, lo); end
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, bc);
    vectors++; if (bc !== 3) begin errors++; $display("FAIL multu_busy got %0d want 3", bc); end
    vectors++; if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_hilo got %h_%h want 00000002_fffffffa", hi, lo); end
  endtask

  task automatic test_div;
    int bc;
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc);
    vectors++; if (bc !== 33) begin errors++; $display("FAIL div_busy got %0d want 33", bc); end
    vectors++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
    run_op(3'd4, 32'd100, 32'd7, bc);
    vectors++; if (bc !== 33) begin errors++; $display("FAIL divu_busy got %0d want 33", bc); end
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu got lo=%0d hi=%0d want 14/2", lo, hi); end
  endtask

  task automatic test_div_boundary;
    int bc;
    run_op(3'd5, 32'h0000_AAAA, 32'd0, bc);
    run_op(3'd6, 32'h0000_5555, 32'd0, bc);
    run_op(3'd3, 32'd5, 32'd0, bc);
    vectors++; if (bc !== 33) begin errors++; $display("FAIL divzero_busy got %0d want 33", bc); end
    vectors++; if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin errors++; $display("FAIL divzero_hilo got %h/%h want 0000aaaa/00005555", hi, lo); end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    vectors++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin errors++; $display("FAIL div_wrap got lo=%h hi=%h want 80000000/00000000", lo, hi); end
  endtask

  task automatic test_mul;
    int bc;
    run_op(3'd5, 32'h0000_0AAA, 32'd0, bc);
    run_op(3'd6, 32'h0000_0555, 32'd0, bc);
    run_op(3'd7, 32'd6, 32'd7, bc);
    vectors++; if (bc !== 3) begin errors++; $display("FAIL mul_busy got %0d want 3", bc); end
    vectors++; if (mul_done !== 1'b1 || mul_result !== 32'd42) begin errors++; $display("FAIL mul_done got %b/%0d want 1/42", mul_done, mul_result); end
    @(negedge clk);
    vectors++; if (mul_done !== 1'b0) begin errors++; $display("FAIL mul_pulse got %b want 0", mul_done); end
    vectors++; if (hi !== 32'h0000_0AAA || lo !== 32'h0000_0555) begin errors++; $display("FAIL mul_hilo got %h/%h want 00000aaa/00000555", hi, lo); end
  endtask

  task automatic test_flush;
    int seen;
    seen = 0;
    flush = 1'b1; op_valid = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy) seen++;
      @(negedge clk);
    end
    vectors++; if (seen !== 0) begin errors++; $display("FAIL flush_busy got %0d busy cycles want 0", seen); end
    vectors++; if (hi !== 32'h0000_0AAA || lo !== 32'h0000_0555) begin errors++; $display("FAIL flush_hilo got %h/%h want 00000aaa/00000555", hi, lo); end
  endtask

  task automatic test_abort;
    int bc;
    run_op(3'd5, 32'h11, 32'd0, bc);
    run_op(3'd6, 32'h22, 32'd0, bc);
    // Abort in DIV_FIX (cycle 33, the completing edge).
    op_valid = 1'b1; op = 3'd4; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    repeat (32) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_div_pre got %0b want 1", busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_div_busy got %0b want 0", busy); end
    vectors++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL abort_div_hilo got %h/%h want 00000011/00000022", hi, lo); end
    // Abort in MUL cycle 1.
    op_valid = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_mul_busy got %0b want 0", busy); end
    repeat (3) @(negedge clk);
    vectors++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL abort_mul_hilo got %h/%h want 00000011/00000022", hi, lo); end
    // abort with an op offered in IDLE: the op is still accepted.
    abort = 1'b1;
    run_op(3'd6, 32'h77, 32'd0, bc);
    abort = 1'b0;
    vectors++; if (lo !== 32'h77) begin errors++; $display("FAIL abort_idle_lo got %h want 00000077", lo); end
  endtask

  task automatic test_busy_ignore;
    int bc;
    op_valid = 1'b1; op = 3'd1; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    src_a = 32'd100; src_b = 32'd100;   // offered while busy: must be ignored
    repeat (2) @(negedge clk);
    op_valid = 1'b0; op = 3'd0;
    bc = 2;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    vectors++; if (bc !== 3) begin errors++; $display("FAIL ignore_busy got %0d want 3", bc); end
    vectors++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL ignore_hilo got %h/%h want 00000000/00000006", hi, lo); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_rerun got %0b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int bc;
    run_op(3'd2, 32'd7, 32'd9, bc);
    vectors++; if (hi !== 32'd0 || lo !== 32'd63) begin errors++; $display("FAIL b2b_mult got %h/%h want 00000000/0000003f", hi, lo); end
    run_op(3'd4, 32'd1000, 32'd33, bc);
    vectors++; if (bc !== 33 || lo !== 32'd30 || hi !== 32'd10) begin errors++; $display("FAIL b2b_divu got bc=%0d lo=%0d hi=%0d want 33/30/10", bc, lo, hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_boundary();
    test_mul();
    test_flush();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
